test_adder: RTL and testbench
=============================

Name: test_adder

Overview:
- Parameterised WIDTH-bit binary adder with carry-in and carry-out.
- Common arithmetic primitive for datapath blocks and bring-up.
- Two result paths:
  - a zero-latency combinational path (sum/cout);
  - a one-cycle registered path with valid strobe and signed-overflow flag, for timing-closed consumers.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CLA_BITS, 4, width of each carry-lookahead group; last group may be narrower when WIDTH is not a multiple.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned (also read as two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- in_valid  input  1  capture strobe for the registered path.
- sum  output  WIDTH  combinational (a+b+cin) mod 2^WIDTH.
- cout  output  1  combinational carry-out, bit WIDTH of a+b+cin.
- ovf  output  1  combinational signed overflow.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.
- ovf_q  output  1  registered signed overflow.
- out_valid  output  1  registered-result valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Combinational path:
  - {cout,sum} = a + b + cin, computed at WIDTH+1 bits; no clock or reset dependence.
  - Must settle within the same delta/timestep as input change.
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
- Carry chain:
  - Built from CLA_BITS-wide lookahead groups (generate/propagate), rippled between groups.
  - Result must be bit-identical to a behavioural '+'.
- Registered path, on each rising clk:
  - rst=1: sum_q=0, cout_q=0, ovf_q=0, out_valid=0 (dominates in_valid).
  - else in_valid=1: sum_q/cout_q/ovf_q take the current combinational values; out_valid=1.
  - else: result registers hold; out_valid=0.
- Latency: exactly 1 cycle; throughput one operation per cycle; back-to-back in_valid allowed.
- No backpressure: out_valid is a single-cycle pulse per accepted operation.
- Boundaries:
  - All-ones + 1 wraps to 0 with cout=1.
  - Carry-in alone can produce carry-out (e.g. all-ones+0+1).
  - X/Z inputs are not required to propagate cleanly.
- Reset mid-operation: an in_valid coincident with rst is discarded.
- Combinational outputs keep following inputs during reset.

Decomposition:
- Shared arith package: default WIDTH, CLA_BITS constants; helper function computing group count ceil(WIDTH/CLA_BITS).
- One sub-module, test_adder_cla_group:
  - ports: group width parameter, a/b slice, carry-in;
  - outputs: sum slice, group generate, group propagate, carry-out.
- Top instantiates groups via generate, chains carries, and adds the output register stage.

Test Plan:
- WIDTH=8, a=10,b=20,cin=0 -> sum=30, cout=0, ovf=0 (combinational, same timestep).
- a=100,b=200,cin=0 -> sum=44, cout=1, ovf=0.
- a=255,b=1,cin=0 -> sum=0, cout=1; a=128,b=127,cin=1 -> sum=0, cout=1, ovf=0.
- a=127,b=1,cin=0 -> sum=128, cout=0, ovf=1.
- Registered path:
  - stimulus: rst high 2 cycles, then in_valid pulses with (10,20,0) then (255,1,0) on consecutive edges;
  - required response: out_valid=0 during reset; one edge later sum_q=30/cout_q=0; next edge sum_q=0/cout_q=1; out_valid drops when in_valid drops.
- Assert rst together with in_valid=1 (a=5,b=5) -> sum_q=0, out_valid=0 next cycle.
- Random sweep (≥10k vectors, WIDTH=8 and WIDTH=13) vs behavioural model, all three combinational outputs.

Source files
------------

// File: rtl/test_adder_pkg.sv
// Shared arithmetic constants and helpers for the test_adder family.
package test_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_CLA_BITS = 4;

  // Number of lookahead groups needed to cover w bits (last group may be narrow).
  function automatic int unsigned num_groups(input int unsigned w, input int unsigned cb);
    return (w + cb - 1) / cb;
  endfunction

endpackage

// File: rtl/test_adder_cla_group.sv
// One carry-lookahead group: GW-bit slice add with group generate/propagate.
// Ports:
//   a, b  : operand slices
//   cin   : carry into the group
//   sum   : slice result
//   gen   : group generates a carry regardless of cin
//   prop  : group passes cin straight through (all bits propagate)
//   cout  : carry out of the group for the given cin
module test_adder_cla_group #(
  parameter int unsigned GW = 4
) (
  input  logic [GW-1:0] a,
  input  logic [GW-1:0] b,
  input  logic          cin,
  output logic [GW-1:0] sum,
  output logic          gen,
  output logic          prop,
  output logic          cout
);

  logic [GW-1:0] g_bit;
  logic [GW-1:0] p_bit;
  logic [GW:0]   c;

  // Bit-level generate/propagate, in-group carries and the folded group G/P.
  always_comb begin
    g_bit = a & b;
    p_bit = a ^ b;
    c     = '0;
    c[0]  = cin;
    gen   = 1'b0;
    prop  = 1'b1;
    for (int i = 0; i < int'(GW); i++) begin
      c[i+1] = g_bit[i] | (p_bit[i] & c[i]);
      gen    = g_bit[i] | (p_bit[i] & gen);
      prop   = prop & p_bit[i];
    end
    sum  = p_bit ^ c[GW-1:0];
    cout = c[GW];
  end

endmodule

// File: rtl/test_adder.sv
// WIDTH-bit adder with carry-in/out: zero-latency combinational result plus a
// one-cycle registered copy with valid strobe and signed-overflow flag.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (registered path only)
//   a, b, cin         : operands and carry-in
//   in_valid          : capture strobe for the registered path
//   sum, cout, ovf    : combinational result, carry-out, signed overflow
//   sum_q, cout_q,
//   ovf_q, out_valid  : registered result and single-cycle valid pulse
module test_adder
  import test_adder_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned CLA_BITS = DEFAULT_CLA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  localparam int unsigned NG = num_groups(WIDTH, CLA_BITS);

  logic [NG:0]   carry;
  logic [NG-1:0] grp_gen;
  logic [NG-1:0] grp_prop;
  logic [NG-1:0] grp_cout;
  logic          unused_grp_cout;

  assign carry[0] = cin;

  // Lookahead groups; inter-group carry formed from group G/P.
  for (genvar gi = 0; gi < int'(NG); gi++) begin : g_grp
    localparam int unsigned LO = 32'(gi) * CLA_BITS;
    localparam int unsigned GW = (LO + CLA_BITS > WIDTH) ? (WIDTH - LO) : CLA_BITS;

    test_adder_cla_group #(.GW(GW)) u_grp (
      .a    (a[LO +: GW]),
      .b    (b[LO +: GW]),
      .cin  (carry[gi]),
      .sum  (sum[LO +: GW]),
      .gen  (grp_gen[gi]),
      .prop (grp_prop[gi]),
      .cout (grp_cout[gi])
    );

    assign carry[gi+1] = grp_gen[gi] | (grp_prop[gi] & carry[gi]);
  end

  // Group ripple carry-outs duplicate the lookahead carries; only the G/P form is used.
  assign unused_grp_cout = ^grp_cout;

  assign cout = carry[NG];
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // Output register stage; reset wins over a coincident in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
        ovf_q  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_test_adder.sv
module tb_test_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, cin, in_valid;
  logic [7:0] a, b, sum, sum_q;
  logic       cout, ovf, cout_q, ovf_q, out_valid;

  logic [12:0] a13, b13, sum13, sum_q13;
  logic        cin13, cout13, ovf13, cout_q13, ovf_q13, out_valid13;
  logic        in_valid13;

  int checks = 0;
  int errors = 0;

  test_adder #(.WIDTH(8), .CLA_BITS(4)) dut8 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .ovf(ovf),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q), .out_valid(out_valid)
  );

  test_adder #(.WIDTH(13), .CLA_BITS(4)) dut13 (
    .clk(clk), .rst(rst), .a(a13), .b(b13), .cin(cin13), .in_valid(in_valid13),
    .sum(sum13), .cout(cout13), .ovf(ovf13),
    .sum_q(sum_q13), .cout_q(cout_q13), .ovf_q(ovf_q13), .out_valid(out_valid13)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer add; overflow from signed range. Returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input int unsigned w, input longint unsigned x,
                                        input longint unsigned y, input bit c);
    longint unsigned full, tot;
    longint          half, sx, sy, s;
    logic [65:0]     r;
    full = 64'd1 << w;
    half = longint'(full >> 1);
    tot  = x + y + 64'(c);
    sx   = (longint'(x) >= half) ? longint'(x) - longint'(full) : longint'(x);
    sy   = (longint'(y) >= half) ? longint'(y) - longint'(full) : longint'(y);
    s    = sx + sy + longint'(c);
    r[63:0] = tot & (full - 64'd1);
    r[64]   = tot[w];
    r[65]   = (s > half - 1) || (s < -half);
    return r;
  endfunction

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t        tbl[6];
  logic [65:0] m, m13;
  logic [7:0]  e_sum;
  logic        e_cout, e_ovf, e_valid;

  initial begin
    tbl[0] = '{8'd10,  8'd20,  1'b0, 8'd30,  1'b0, 1'b0};
    tbl[1] = '{8'd100, 8'd200, 1'b0, 8'd44,  1'b1, 1'b0};
    tbl[2] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
    tbl[3] = '{8'd128, 8'd127, 1'b1, 8'd0,   1'b1, 1'b0};
    tbl[4] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    tbl[5] = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_valid13 = 1'b0;
    a = '0; b = '0; cin = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;

    // Combinational vectors (held in reset: comb path must still follow inputs)
    for (int i = 0; i < 6; i++) begin
      a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
      #1;
      chk($sformatf("tbl%0d_sum", i),  64'(sum),  64'(tbl[i].sum));
      chk($sformatf("tbl%0d_cout", i), 64'(cout), 64'(tbl[i].cout));
      chk($sformatf("tbl%0d_ovf", i),  64'(ovf),  64'(tbl[i].ovf));
    end

    // Two reset cycles
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum_q", 64'(sum_q), 64'd0);
    chk("rst_cout_q", 64'(cout_q), 64'd0);
    chk("rst_ovf_q", 64'(ovf_q), 64'd0);

    // Back-to-back captures
    rst = 1'b0; in_valid = 1'b1; a = 8'd10; b = 8'd20; cin = 1'b0;
    @(posedge clk); #1;
    chk("reg1_sum_q", 64'(sum_q), 64'd30);
    chk("reg1_cout_q", 64'(cout_q), 64'd0);
    chk("reg1_valid", 64'(out_valid), 64'd1);
    a = 8'd255; b = 8'd1;
    @(posedge clk); #1;
    chk("reg2_sum_q", 64'(sum_q), 64'd0);
    chk("reg2_cout_q", 64'(cout_q), 64'd1);
    chk("reg2_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0; a = 8'd3; b = 8'd4;
    @(posedge clk); #1;
    chk("hold_valid", 64'(out_valid), 64'd0);
    chk("hold_sum_q", 64'(sum_q), 64'd0);
    chk("hold_cout_q", 64'(cout_q), 64'd1);
    in_valid = 1'b1; a = 8'd127; b = 8'd1;
    @(posedge clk); #1;
    chk("reg3_sum_q", 64'(sum_q), 64'd128);
    chk("reg3_ovf_q", 64'(ovf_q), 64'd1);

    // Reset coincident with in_valid: capture discarded
    rst = 1'b1; in_valid = 1'b1; a = 8'd5; b = 8'd5; cin = 1'b0;
    #1;
    chk("rst_comb_sum", 64'(sum), 64'd10);
    @(posedge clk); #1;
    chk("rstv_sum_q", 64'(sum_q), 64'd0);
    chk("rstv_valid", 64'(out_valid), 64'd0);
    chk("rstv_ovf_q", 64'(ovf_q), 64'd0);
    rst = 1'b0; in_valid = 1'b0;

    // Random combinational sweep, both widths
    for (int i = 0; i < 10000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
      #1;
      m   = model(8, 64'(a), 64'(b), cin);
      m13 = model(13, 64'(a13), 64'(b13), cin13);
      chk("rnd8_sum", 64'(sum), m[63:0]);
      chk("rnd8_cout", 64'(cout), 64'(m[64]));
      chk("rnd8_ovf", 64'(ovf), 64'(m[65]));
      chk("rnd13_sum", 64'(sum13), m13[63:0]);
      chk("rnd13_cout", 64'(cout13), 64'(m13[64]));
      chk("rnd13_ovf", 64'(ovf13), 64'(m13[65]));
    end

    // Random registered traffic with occasional reset
    e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      in_valid = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      m = model(8, 64'(a), 64'(b), cin);
      @(posedge clk); #1;
      if (rst) begin
        e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0; e_valid = 1'b0;
      end else if (in_valid) begin
        e_sum = m[7:0]; e_cout = m[64]; e_ovf = m[65]; e_valid = 1'b1;
      end else begin
        e_valid = 1'b0;
      end
      chk("rreg_sum_q", 64'(sum_q), 64'(e_sum));
      chk("rreg_cout_q", 64'(cout_q), 64'(e_cout));
      chk("rreg_ovf_q", 64'(ovf_q), 64'(e_ovf));
      chk("rreg_valid", 64'(out_valid), 64'(e_valid));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
